// File: rtl/gate_sweep_ctrl.sv
// Sweeps the two-input gate unit through vectors 00,01,10,11 and checks its five outputs per vector.
// Latency: first vector driven 1 cycle after start; done pulses 4*(DWELL+1)+1 cycles after start.
// Backpressure: none; start is honoured only when idle and is never queued.
module gate_sweep_ctrl #(
    parameter int DWELL = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        x,
    output logic        y,
    input  logic        z_and,
    input  logic        k_and,
    input  logic        b_and,
    input  logic        f_nand,
    input  logic        h_nand,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [3:0]  fail_mask,
    output logic [19:0] result
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);

    state_t      state_q, state_d;
    logic [1:0]  vec_q, vec_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  mask_d;
    logic [19:0] result_d;
    logic        pass_d;
    logic        drv_d;
    logic        and_exp;
    logic [4:0]  rsp;
    logic [4:0]  rsp_exp;

    assign rsp     = {z_and, k_and, b_and, f_nand, h_nand};
    assign and_exp = vec_q[1] & vec_q[0];
    assign rsp_exp = {and_exp, and_exp, and_exp, ~and_exp, ~and_exp};

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        cnt_d    = cnt_q;
        mask_d   = fail_mask;
        result_d = result;
        pass_d   = pass;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = DRIVE;
                    vec_d    = 2'd0;
                    cnt_d    = 8'd0;
                    mask_d   = 4'h0;
                    result_d = 20'h0;
                    pass_d   = 1'b0;
                end
            end
            DRIVE: begin
                if (cnt_q == DWELL_M1) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SAMPLE: begin
                result_d[5*int'(vec_q) +: 5] = rsp;
                if (rsp != rsp_exp) begin
                    mask_d[vec_q] = 1'b1;
                end
                // pass must see the last vector's mismatch, so it is derived from mask_d
                if (vec_q == 2'd3) begin
                    state_d = DONE;
                    pass_d  = (mask_d == 4'h0);
                end else begin
                    state_d = DRIVE;
                    vec_d   = vec_q + 2'd1;
                    cnt_d   = 8'd0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign drv_d = (state_d == DRIVE) || (state_d == SAMPLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            vec_q     <= 2'd0;
            cnt_q     <= 8'd0;
            fail_mask <= 4'h0;
            result    <= 20'h0;
            pass      <= 1'b0;
            x         <= 1'b0;
            y         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            cnt_q     <= cnt_d;
            fail_mask <= mask_d;
            result    <= result_d;
            pass      <= pass_d;
            x         <= drv_d & vec_d[1];
            y         <= drv_d & vec_d[0];
            busy      <= drv_d;
            done      <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: two instances (DWELL=4 and DWELL=1) with fault-injectable gate units,
// directed scenarios followed by random start/reset traffic, all checked against a sweep-level model.
module tb_gate_sweep_ctrl;

    logic        clk;
    logic        rst;
    logic        start_v [2];
    logic        x_w     [2];
    logic        y_w     [2];
    logic [4:0]  rsp_w   [2];
    logic        busy_w  [2];
    logic        done_w  [2];
    logic        pass_w  [2];
    logic [3:0]  mask_w  [2];
    logic [19:0] res_w   [2];
    logic [4:0]  st_en   [2];
    logic [4:0]  st_val  [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: a sweep is tracked only by its cycle offset k from the accepted start.
    bit          m_act  [2];
    int          m_k    [2];
    logic [3:0]  m_mask [2];
    logic [19:0] m_res  [2];
    logic        m_pass [2];

    function automatic logic [4:0] gate_fn(input logic a, input logic b,
                                           input logic [4:0] en, input logic [4:0] val);
        logic g;
        g = a & b;
        return ({g, g, g, ~g, ~g} & ~en) | (val & en);
    endfunction

    function automatic int dw(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_dut
            gate_sweep_ctrl #(.DWELL((g == 0) ? 4 : 1)) dut (
                .clk       (clk),
                .rst       (rst),
                .start     (start_v[g]),
                .x         (x_w[g]),
                .y         (y_w[g]),
                .z_and     (rsp_w[g][4]),
                .k_and     (rsp_w[g][3]),
                .b_and     (rsp_w[g][2]),
                .f_nand    (rsp_w[g][1]),
                .h_nand    (rsp_w[g][0]),
                .busy      (busy_w[g]),
                .done      (done_w[g]),
                .pass      (pass_w[g]),
                .fail_mask (mask_w[g]),
                .result    (res_w[g])
            );
            assign rsp_w[g] = gate_fn(x_w[g], y_w[g], st_en[g], st_val[g]);
        end
    endgenerate

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int p;
            int v;
            logic [1:0] vb;
            logic [4:0] r;
            p = dw(i) + 1;
            if (rst) begin
                m_act[i]  = 0;
                m_k[i]    = 0;
                m_mask[i] = 4'h0;
                m_res[i]  = 20'h0;
                m_pass[i] = 1'b0;
            end else if (m_act[i]) begin
                if (m_k[i] % p == 0 && m_k[i] <= 4 * p) begin
                    v  = m_k[i] / p - 1;
                    vb = 2'(v);
                    r  = gate_fn(vb[1], vb[0], st_en[i], st_val[i]);
                    m_res[i][5*v +: 5] = r;
                    if (r != gate_fn(vb[1], vb[0], 5'h0, 5'h0)) m_mask[i][v] = 1'b1;
                    if (m_k[i] == 4 * p) m_pass[i] = (m_mask[i] == 4'h0);
                end
                if (m_k[i] == 4 * p + 1) m_act[i] = 0;
                else m_k[i] = m_k[i] + 1;
            end else if (start_v[i]) begin
                m_act[i]  = 1;
                m_k[i]    = 1;
                m_mask[i] = 4'h0;
                m_res[i]  = 20'h0;
                m_pass[i] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int p;
            int vi;
            logic [1:0] vb;
            logic eb;
            p  = dw(i) + 1;
            eb = m_act[i] && (m_k[i] <= 4 * p);
            vi = (m_k[i] > 0) ? (m_k[i] - 1) / p : 0;
            vb = eb ? 2'(vi) : 2'd0;
            check($sformatf("busy%0d", i), busy_w[i], eb);
            check($sformatf("done%0d", i), done_w[i], m_act[i] && (m_k[i] == 4 * p + 1));
            check($sformatf("x%0d", i), x_w[i], vb[1]);
            check($sformatf("y%0d", i), y_w[i], vb[0]);
            check($sformatf("pass%0d", i), pass_w[i], m_pass[i]);
            check($sformatf("mask%0d", i), mask_w[i], m_mask[i]);
            check($sformatf("res%0d", i), res_w[i], m_res[i]);
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
    endtask

    // Returns the cycle (counted from the start cycle as 0) in which done is observed.
    task automatic run_sweep(input int i, input bit poke, output int lat);
        start_v[i] = 1'b1;
        step();
        start_v[i] = 1'b0;
        lat = 1;
        while (done_w[i] !== 1'b1 && lat < 100) begin
            step();
            lat++;
            start_v[i] = poke && (lat == 5);
        end
        if (poke) start_v[i] = 1'b1;
    endtask

    initial begin
        int lat;
        rst        = 1'b1;
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        st_en[0]   = 5'h0;
        st_en[1]   = 5'h0;
        st_val[0]  = 5'h0;
        st_val[1]  = 5'h0;
        step();
        step();
        rst = 1'b0;
        check("rst_res", res_w[0], 20'h0);
        check("rst_mask", mask_w[0], 4'h0);
        check("rst_busy", busy_w[0], 1'b0);
        check("rst_pass", pass_w[0], 1'b0);

        run_sweep(0, 1'b0, lat);
        check("good_cyc", lat, 21);
        check("good_res", res_w[0], 20'hE0C63);
        check("good_mask", mask_w[0], 4'h0);
        check("good_pass", pass_w[0], 1'b1);
        step();

        st_en[0]  = 5'b00010;
        st_val[0] = 5'b00010;
        run_sweep(0, 1'b0, lat);
        check("fnand_cyc", lat, 21);
        check("fnand_mask", mask_w[0], 4'b1000);
        check("fnand_slot3", {27'h0, res_w[0][19:15]}, 32'b11110);
        check("fnand_pass", pass_w[0], 1'b0);
        step();

        st_en[0]  = 5'b10000;
        st_val[0] = 5'b10000;
        run_sweep(0, 1'b0, lat);
        check("zand_mask", mask_w[0], 4'b0111);
        check("zand_pass", pass_w[0], 1'b0);
        step();

        st_en[0]  = 5'h0;
        run_sweep(0, 1'b1, lat);
        check("poke_cyc", lat, 21);
        step();
        start_v[0] = 1'b0;
        check("poke_idle", busy_w[0], 1'b0);
        check("poke_hold", mask_w[0], 4'b0111 & 4'h0);
        run_sweep(0, 1'b0, lat);
        check("restart_cyc", lat, 21);
        step();

        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_busy", busy_w[0], 1'b0);
        check("mid_rst_res", res_w[0], 20'h0);
        check("mid_rst_x", x_w[0], 1'b0);
        check("mid_rst_done", done_w[0], 1'b0);
        run_sweep(0, 1'b0, lat);
        check("post_rst_cyc", lat, 21);
        check("post_rst_pass", pass_w[0], 1'b1);

        run_sweep(1, 1'b0, lat);
        check("dw1_cyc", lat, 9);
        check("dw1_pass", pass_w[1], 1'b1);
        check("dw1_res", res_w[1], 20'hE0C63);
        step();

        repeat (3000) begin
            for (int i = 0; i < 2; i++) begin
                start_v[i] = ($urandom_range(5) == 0);
                if (!m_act[i] && $urandom_range(3) == 0) begin
                    st_en[i]  = ($urandom_range(2) == 0) ? 5'($urandom) : 5'h0;
                    st_val[i] = 5'($urandom);
                end
            end
            rst = ($urandom_range(299) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
